// File: rtl/shapool_pkg.sv
// Shared constants and types for the shapool job controller: job framing,
// field positions inside the assembled job word, and controller states.
package shapool_pkg;

  localparam int JOB_BYTES     = 47;
  localparam int JOB_BITS      = 376;
  localparam int BYTE_CNT_W    = 6;

  localparam int SHA_STATE_MSB = 375;
  localparam int MSG_HEAD_MSB  = 119;
  localparam int DIFF_MSB      = 23;
  localparam int NONCE_MSB_MSB = 7;

  localparam int SHA_ROUNDS    = 64;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/shapool_job_shifter.sv
// Byte-wide MSB-first job shift register with byte counter; flags the
// acceptance of the final job byte and exposes the fully assembled word.
module shapool_job_shifter
  import shapool_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                accept_i,
  input  logic [7:0]          byte_i,
  output logic [JOB_BITS-1:0] job_word_o,
  output logic                last_o
);

  // The newest byte is never stored: the full word is formed combinationally
  // on the edge that accepts it, so only the older bytes need flops.
  logic [JOB_BITS-9:0]   shift_q, shift_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    job_word_o = {shift_q, byte_i};
    last_o     = accept_i && !clear_i && (byte_cnt_q == BYTE_CNT_W'(JOB_BYTES - 1));
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (clear_i) begin
      byte_cnt_d = '0;
    end else if (accept_i) begin
      shift_d    = {shift_q[JOB_BITS-17:0], byte_i};
      byte_cnt_d = last_o ? '0 : byte_cnt_q + BYTE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/shapool_job_ctrl.sv
// Job controller for the shapool hashing pool: loads a 47-byte job, runs the
// pool until success or segment exhaustion, then holds one result until ack.
module shapool_job_ctrl
  import shapool_pkg::*;
#(
  parameter  int POOL_SIZE_LOG2 = 0,
  parameter  int NONCE_LAG      = 2,
  parameter  int DRAIN_CYCLES   = 128,
  localparam int NONCE_WIDTH    = 32 - POOL_SIZE_LOG2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   abort,
  output logic [255:0]           sha_state,
  output logic [95:0]            message_head,
  output logic [15:0]            difficulty_bm,
  output logic [7:0]             nonce_start_MSB,
  output logic                   pool_reset_n,
  input  logic                   pool_success,
  input  logic [NONCE_WIDTH-1:0] pool_nonce,
  output logic                   result_valid,
  output logic                   result_found,
  output logic [NONCE_WIDTH-1:0] result_nonce,
  input  logic                   result_ack
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;

  ctrl_state_e            state_q, state_d;
  logic [JOB_BITS-1:0]    job_word_s;
  logic                   last_byte_s;
  logic                   exhausted_s;

  logic [255:0]           sha_state_q, sha_state_d;
  logic [95:0]            message_head_q, message_head_d;
  logic [15:0]            difficulty_bm_q, difficulty_bm_d;
  logic [7:0]             nonce_msb_q, nonce_msb_d;
  logic                   result_valid_q, result_valid_d;
  logic                   result_found_q, result_found_d;
  logic [NONCE_WIDTH-1:0] result_nonce_q, result_nonce_d;
  logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;

  shapool_job_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (abort),
    .accept_i   (in_valid && in_ready),
    .byte_i     (in_data),
    .job_word_o (job_word_s),
    .last_o     (last_byte_s)
  );

  // The segment is used up once the pool counter's top byte moves past the job's.
  assign exhausted_s = (pool_nonce[NONCE_WIDTH-1 -: 8] == (nonce_msb_q + 8'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  state_d = last_byte_s ? ST_RUN : ST_LOAD;
        ST_RUN:   state_d = pool_success ? ST_DONE : (exhausted_s ? ST_DRAIN : ST_RUN);
        ST_DRAIN: state_d = (pool_success || (drain_cnt_q == '0)) ? ST_DONE : ST_DRAIN;
        ST_DONE:  state_d = result_ack ? ST_LOAD : ST_DONE;
        default:  state_d = ST_LOAD;
      endcase
    end
  end

  always_comb begin
    in_ready     = (state_q == ST_LOAD);
    pool_reset_n = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  end

  always_comb begin
    sha_state_d     = sha_state_q;
    message_head_d  = message_head_q;
    difficulty_bm_d = difficulty_bm_q;
    nonce_msb_d     = nonce_msb_q;
    result_valid_d  = result_valid_q;
    result_found_d  = result_found_q;
    result_nonce_d  = result_nonce_q;
    drain_cnt_d     = drain_cnt_q;
    if (last_byte_s) begin
      sha_state_d     = job_word_s[SHA_STATE_MSB -: 256];
      message_head_d  = job_word_s[MSG_HEAD_MSB -: 96];
      difficulty_bm_d = job_word_s[DIFF_MSB -: 16];
      nonce_msb_d     = job_word_s[NONCE_MSB_MSB -: 8];
    end
    if (abort) begin
      result_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_DRAIN: begin
          if (pool_success) begin
            result_nonce_d = pool_nonce - NONCE_WIDTH'(NONCE_LAG);
            result_found_d = 1'b1;
            result_valid_d = 1'b1;
          end else if (state_q == ST_RUN) begin
            if (exhausted_s) drain_cnt_d = DRAIN_W'(DRAIN_CYCLES - 1);
          end else if (drain_cnt_q == '0) begin
            result_nonce_d = '0;
            result_found_d = 1'b0;
            result_valid_d = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          if (result_ack) begin
            result_valid_d = 1'b0;
            result_found_d = 1'b0;
          end
        end
        default: begin
          drain_cnt_d = drain_cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sha_state_q     <= '0;
      message_head_q  <= '0;
      difficulty_bm_q <= '0;
      nonce_msb_q     <= '0;
      result_valid_q  <= 1'b0;
      result_found_q  <= 1'b0;
      result_nonce_q  <= '0;
      drain_cnt_q     <= '0;
    end else begin
      sha_state_q     <= sha_state_d;
      message_head_q  <= message_head_d;
      difficulty_bm_q <= difficulty_bm_d;
      nonce_msb_q     <= nonce_msb_d;
      result_valid_q  <= result_valid_d;
      result_found_q  <= result_found_d;
      result_nonce_q  <= result_nonce_d;
      drain_cnt_q     <= drain_cnt_d;
    end
  end

  assign sha_state       = sha_state_q;
  assign message_head    = message_head_q;
  assign difficulty_bm   = difficulty_bm_q;
  assign nonce_start_MSB = nonce_msb_q;
  assign result_valid    = result_valid_q;
  assign result_found    = result_found_q;
  assign result_nonce    = result_nonce_q;

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// Scoreboard bench for shapool_job_ctrl: stimulus queues expected jobs and
// results; a negedge monitor compares them when the DUT presents them.
module tb_shapool_job_ctrl;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, abort;
  logic [7:0]   in_data;
  logic [255:0] sha_state;
  logic [95:0]  message_head;
  logic [15:0]  difficulty_bm;
  logic [7:0]   nonce_start_MSB;
  logic         pool_reset_n, pool_success;
  logic [31:0]  pool_nonce;
  logic         result_valid, result_found, result_ack;
  logic [31:0]  result_nonce;

  always #5 clk = ~clk;

  shapool_job_ctrl dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .sha_state(sha_state),
    .message_head(message_head), .difficulty_bm(difficulty_bm),
    .nonce_start_MSB(nonce_start_MSB), .pool_reset_n(pool_reset_n),
    .pool_success(pool_success), .pool_nonce(pool_nonce),
    .result_valid(result_valid), .result_found(result_found),
    .result_nonce(result_nonce), .result_ack(result_ack)
  );

  typedef struct packed { logic found; logic [31:0] nonce; } res_t;
  typedef struct packed { logic [255:0] sha; logic [95:0] head; logic [15:0] diff; logic [7:0] nmsb; } job_t;

  res_t res_q[$];
  job_t job_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a rising result_valid or pool_reset_n pops the next expectation.
  res_t mon_res;
  job_t mon_job;
  logic prev_rv  = 1'b0;
  logic prev_prn = 1'b0;
  always @(negedge clk) begin
    if (result_valid === 1'b1 && !prev_rv) begin
      if (res_q.size() == 0) begin
        check("unexpected_result", 256'(result_valid), 256'(0));
      end else begin
        mon_res = res_q.pop_front();
        check("result_found", 256'(result_found), 256'(mon_res.found));
        check("result_nonce", 256'(result_nonce), 256'(mon_res.nonce));
      end
    end
    if (pool_reset_n === 1'b1 && !prev_prn) begin
      if (job_q.size() == 0) begin
        check("unexpected_run", 256'(pool_reset_n), 256'(0));
      end else begin
        mon_job = job_q.pop_front();
        check("sha_state", sha_state, mon_job.sha);
        check("message_head", 256'(message_head), 256'(mon_job.head));
        check("difficulty_bm", 256'(difficulty_bm), 256'(mon_job.diff));
        check("nonce_start_MSB", 256'(nonce_start_MSB), 256'(mon_job.nmsb));
      end
    end
    prev_rv  = (result_valid === 1'b1);
    prev_prn = (pool_reset_n === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams bytes base, base+1, ... ; a full job queues its expected fields.
  task automatic send_bytes(input logic [7:0] base, input int count, input bit push);
    logic [375:0] w;
    logic [7:0]   b;
    w = '0;
    for (int i = 0; i < count; i++) begin
      b        = base + 8'(i);
      w        = {w[367:0], b};
      in_data  = b;
      in_valid = 1'b1;
      if (i == 46 && push) job_q.push_back({w[375:120], w[119:24], w[23:8], w[7:0]});
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic push_res(input logic found, input logic [31:0] nonce);
    res_q.push_back({found, nonce});
  endtask

  task automatic success(input logic [31:0] nonce);
    pool_success = 1'b1;
    pool_nonce   = nonce;
    tick();
    pool_success = 1'b0;
  endtask

  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic wait_result(input int bound, output int n);
    n = 0;
    while (result_valid !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    if (result_valid !== 1'b1) check("result_timeout", 256'(result_valid), 256'(1));
  endtask

  int n;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
    pool_success = 1'b0; pool_nonce = 32'h0; result_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_pool_reset_n", 256'(pool_reset_n), 256'(0));
    check("rst_result_valid", 256'(result_valid), 256'(0));
    check("rst_result_nonce", 256'(result_nonce), 256'(0));
    check("rst_sha_state", sha_state, 256'(0));
    check("rst_nonce_msb", 256'(nonce_start_MSB), 256'(0));

    // Job 0x00..0x2E
    send_bytes(8'h00, 47, 1'b1);
    check("t1_pool_reset_n", 256'(pool_reset_n), 256'(1));
    check("t1_in_ready", 256'(in_ready), 256'(0));
    check("t1_sha_top", 256'(sha_state[255:248]), 256'(8'h00));
    check("t1_nonce_msb", 256'(nonce_start_MSB), 256'(8'h2E));
    check("t1_diff", 256'(difficulty_bm), 256'(16'h2C2D));

    push_res(1'b1, 32'h0000_0003);
    success(32'h0000_0005);
    check("t2_pool_held", 256'(pool_reset_n), 256'(0));
    check("t2_result_valid", 256'(result_valid), 256'(1));
    ack();
    check("t2_in_ready", 256'(in_ready), 256'(1));
    check("t2_valid_clr", 256'(result_valid), 256'(0));
    check("t2_found_clr", 256'(result_found), 256'(0));
    check("t2_nonce_kept", 256'(result_nonce), 256'(32'h3));

    // Wrapping nonce subtraction
    send_bytes(8'h10, 47, 1'b1);
    push_res(1'b1, 32'hFFFF_FFFF);
    success(32'h0000_0001);
    ack();

    // Exhaustion and full drain: job nonce_start_MSB = 0x12
    send_bytes(8'hE4, 47, 1'b1);
    check("t4_nonce_msb", 256'(nonce_start_MSB), 256'(8'h12));
    push_res(1'b0, 32'h0);
    pool_nonce = 32'h1300_0000;
    tick();
    check("t4_drain_running", 256'(pool_reset_n), 256'(1));
    wait_result(300, n);
    check("t4_drain_length", 256'(n), 256'(128));
    ack();

    // Success during drain
    send_bytes(8'hE4, 47, 1'b1);
    pool_nonce = 32'h1300_0000;
    tick();
    repeat (50) tick();
    check("t4b_no_early_result", 256'(result_valid), 256'(0));
    push_res(1'b1, 32'h1300_003E);
    success(32'h1300_0040);
    ack();

    // Success and exhaustion on the same cycle
    send_bytes(8'hE4, 47, 1'b1);
    push_res(1'b1, 32'h1300_0005);
    success(32'h1300_0007);
    ack();

    // Abort mid-load, then a full job
    pool_nonce = 32'h0;
    send_bytes(8'h80, 20, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t5_in_ready", 256'(in_ready), 256'(1));
    send_bytes(8'h40, 47, 1'b1);
    push_res(1'b1, 32'h0000_00FE);
    success(32'h0000_0100);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t5_abort_done_valid", 256'(result_valid), 256'(0));
    check("t5_abort_done_ready", 256'(in_ready), 256'(1));
    check("t5_abort_done_pool", 256'(pool_reset_n), 256'(0));
    check("t5_job_kept", 256'(sha_state[255:248]), 256'(8'h40));

    // Abort coinciding with the 47th byte
    send_bytes(8'h70, 46, 1'b0);
    in_data = 8'h9E; in_valid = 1'b1; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    check("t5_last_abort_ready", 256'(in_ready), 256'(1));
    check("t5_last_abort_pool", 256'(pool_reset_n), 256'(0));
    check("t5_last_abort_nmsb", 256'(nonce_start_MSB), 256'(8'h6E));
    send_bytes(8'h20, 47, 1'b1);

    // Bytes offered while running or done are ignored
    in_data = 8'hFF; in_valid = 1'b1;
    repeat (10) tick();
    check("t6_run_sha_top", 256'(sha_state[255:248]), 256'(8'h20));
    check("t6_run_nmsb", 256'(nonce_start_MSB), 256'(8'h4E));
    check("t6_run_ready", 256'(in_ready), 256'(0));
    push_res(1'b1, 32'h0000_0053);
    success(32'h0000_0055);
    repeat (5) tick();
    check("t6_done_nmsb", 256'(nonce_start_MSB), 256'(8'h4E));
    in_valid = 1'b0;
    ack();
    send_bytes(8'h30, 47, 1'b1);
    check("t6_next_nmsb", 256'(nonce_start_MSB), 256'(8'h5E));
    abort = 1'b1; tick(); abort = 1'b0;

    repeat (3) tick();
    check("pending_results", 256'(res_q.size()), 256'(0));
    check("pending_jobs", 256'(job_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shapool_job_ctrl.md
Name: shapool_job_ctrl

Overview:
Upstream job controller for the shapool hashing pool. It receives a 47-byte job over a byte-wide valid/ready stream and presents the fields to the pool as stable outputs. It drives the pool's active-low reset and watches the pool's success/nonce outputs. It reports one result per job (found nonce or segment exhausted) and holds it until acknowledged.

Parameters:
POOL_SIZE_LOG2, 0, log2 of pool units; must match the pool instance.
NONCE_WIDTH, 32-POOL_SIZE_LOG2, local, not overridable; width of the pool nonce counter.
NONCE_LAG, 2, increments between the nonce that produced a success and the pool_nonce value present on that cycle.
DRAIN_CYCLES, 128, cycles kept running after exhaustion is detected, so in-flight hashes can complete.

Ports:
clk  in  1  single clock.
reset  in  1  synchronous, active-high.
in_data  in  8  job byte.
in_valid  in  1  byte valid.
in_ready  out  1  byte accepted when in_valid&in_ready.
abort  in  1  discard current job/result.
sha_state  out  256  job midstate.
message_head  out  96  job message head.
difficulty_bm  out  16  difficulty bitmask.
nonce_start_MSB  out  8  nonce segment MSB.
pool_reset_n  out  1  pool reset, active-low.
pool_success  in  1  pool success strobe.
pool_nonce  in  NONCE_WIDTH  pool nonce counter.
result_valid  out  1  result held.
result_found  out  1  1 = nonce found, 0 = exhausted.
result_nonce  out  NONCE_WIDTH  found nonce, 0 if not found.
result_ack  in  1  consume result.

Behaviour:
- States: LOAD, RUN, DRAIN, DONE. Reset enters LOAD with byte_cnt=0. All outputs reset to 0 except in_ready=1 (LOAD).
- pool_reset_n = 1 only in RUN or DRAIN. It is decoded from the state register, so the pool is held in reset in LOAD and DONE.
- LOAD:
  - in_ready=1.
  - Each accepted byte shifts MSB-first into a 376-bit register; byte_cnt increments.
  - Field order on the wire: sha_state[255:248] first … sha_state, then message_head, then difficulty_bm, then nonce_start_MSB (last byte).
  - On acceptance of byte 47 (byte_cnt=46), all four job outputs load from the shift register in the same edge. The state becomes RUN, byte_cnt clears, and in_ready drops next cycle.
  - Job outputs are otherwise stable; they change only on that edge or on reset.
- RUN:
  - in_ready=0; bytes are ignored.
  - If pool_success=1: result_nonce <= (pool_nonce - NONCE_LAG) mod 2^NONCE_WIDTH, result_found<=1, result_valid<=1, then DONE.
  - Else if pool_nonce[NONCE_WIDTH-1:NONCE_WIDTH-8] == nonce_start_MSB+1 (mod 256): drain counter <= DRAIN_CYCLES-1, then DRAIN.
- DRAIN:
  - pool_success is handled as in RUN (success wins).
  - Counter decrements each cycle. When it reaches 0 with no success: result_found<=0, result_nonce<=0, result_valid<=1, then DONE.
- DONE:
  - result_* held.
  - result_ack=1 clears result_valid and result_found, then LOAD. result_nonce keeps its value until next capture.
- abort=1 in any state:
  - Next state LOAD, byte_cnt<=0, result_valid<=0, pool_reset_n low next cycle.
  - Job outputs keep their last values.
- Precedence: reset > abort > success > exhaustion/drain > ack.
- Success and exhaustion on the same cycle: success is taken.
- Abort coinciding with the 47th byte: the byte is discarded and job outputs are not updated.
- Nonce subtraction wraps modulo 2^NONCE_WIDTH.
- The pool unit index is not reported; host software resolves the full 32-bit nonce.

Decomposition:
- Shared package shapool_pkg holds:
  - JOB_BYTES=47 and JOB_BITS=376.
  - Field bit offsets within the shift register (SHA_STATE_MSB=375, MSG_HEAD_MSB=119, DIFF_MSB=23, NONCE_MSB_MSB=7).
  - The state enum and SHA_ROUNDS=64.
- One natural sub-module: shapool_job_shifter (376-bit byte shift register plus byte counter, asserting a last-byte strobe).

Test Plan:
1. Reset, then stream bytes 0x00..0x2E → after byte 47: sha_state[255:248]=0x00, nonce_start_MSB=0x2E, difficulty_bm=0x2C2D. State RUN next cycle; pool_reset_n=1, in_ready=0.
2. In RUN, drive pool_success=1 with pool_nonce=0x0000_0005 (POOL_SIZE_LOG2=0) → result_valid=1, result_found=1, result_nonce=0x0000_0003. Pool held in reset; ack returns to LOAD, in_ready=1.
3. Success with pool_nonce=0x0000_0001 → result_nonce=0xFFFF_FFFF (wrap).
4. nonce_start_MSB=0x12; drive pool_nonce=0x1300_0000 → DRAIN. No success for 128 cycles → result_found=0, result_nonce=0. A success at drain cycle 50 instead gives result_found=1.
5. Abort after byte 20, then a full 47-byte job → outputs reflect only the second job. Abort in DONE clears result_valid, with no ack needed.
6. in_valid held high during RUN/DONE with data 0xFF → no change to job outputs or byte_cnt.
